// File: rtl/crack_ctrl.sv
// Brute-force candidate sequencer for a SHA-256 core: walks passwords in
// length-then-lexicographic order, feeds each to the core and compares digests.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// CRST  | one-cycle core reset between candidates
// FEED  | one candidate byte per cycle, char 0 first
// WAIT  | end-of-message held, waiting for the core digest
// CMP   | count attempt, compare registered digest with target
// NEXT  | odometer step to the next candidate
// FOUND | match latched, holds until start/abort
// EXH   | search space exhausted, holds until start/abort
// ERR   | core overflow reported, holds until start/abort
module crack_ctrl #(
   parameter int          MAX_LEN      = 8,
   parameter int          CHARSET_SIZE = 26,
   parameter logic [7:0]  CHAR_BASE    = 8'h61
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [255:0]           target_hash_i,
   input  logic [3:0]             cfg_max_len_i,
   output logic                   sha_rst_o,
   output logic                   byte_rdy_o,
   output logic                   byte_stop_o,
   output logic [7:0]             data_in_o,
   input  logic                   hash_done_i,
   input  logic [255:0]           hash_digest_i,
   input  logic                   overflow_err_i,
   output logic                   busy_o,
   output logic                   found_o,
   output logic                   exhausted_o,
   output logic                   err_o,
   output logic [8*MAX_LEN-1:0]   found_pwd_o,
   output logic [3:0]             found_len_o,
   output logic [31:0]            attempts_o
);

   localparam int SW = (CHARSET_SIZE > 1) ? $clog2(CHARSET_SIZE) : 1;
   localparam logic [SW-1:0] SYM_LAST = SW'(CHARSET_SIZE - 1);
   localparam logic [3:0] MAX_LEN_C = 4'(MAX_LEN);

   typedef enum logic [3:0] {
      S_IDLE, S_CRST, S_FEED, S_WAIT, S_CMP, S_NEXT, S_FOUND, S_EXH, S_ERR
   } state_t;

   state_t                 state_q, state_d;
   logic [255:0]           target_q, target_d;
   logic [255:0]           digest_q, digest_d;
   logic [3:0]             max_q, max_d;
   logic [3:0]             len_q, len_d;
   logic [3:0]             idx_q, idx_d;
   logic [SW-1:0]          sym_q [MAX_LEN];
   logic [SW-1:0]          sym_d [MAX_LEN];
   logic [31:0]            attempts_q, attempts_d;
   logic [8*MAX_LEN-1:0]   fpwd_q, fpwd_d;
   logic [3:0]             flen_q, flen_d;

   logic [SW-1:0]          inc_sym [MAX_LEN];
   logic                   inc_carry;
   logic [SW-1:0]          cur_sym;
   logic [8*MAX_LEN-1:0]   cand_pwd;
   logic [3:0]             clamp_len;
   logic                   start_ok;

   // Odometer: rightmost active symbol is least significant.
   always_comb begin
      inc_carry = 1'b1;
      for (int i = MAX_LEN - 1; i >= 0; i--) begin
         inc_sym[i] = sym_q[i];
         if ((4'(i) < len_q) && inc_carry) begin
            if (sym_q[i] == SYM_LAST) begin
               inc_sym[i] = '0;
            end else begin
               inc_sym[i] = sym_q[i] + 1'b1;
               inc_carry  = 1'b0;
            end
         end
      end
   end

   always_comb begin
      cur_sym  = '0;
      cand_pwd = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (4'(i) == idx_q) cur_sym = sym_q[i];
         if (4'(i) < len_q) cand_pwd[8*i +: 8] = CHAR_BASE + 8'(sym_q[i]);
      end
   end

   assign clamp_len = (cfg_max_len_i > MAX_LEN_C) ? MAX_LEN_C : cfg_max_len_i;
   assign start_ok  = start_i && ((state_q == S_IDLE) || (state_q == S_FOUND) ||
                                  (state_q == S_EXH)  || (state_q == S_ERR));

   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      digest_d    = digest_q;
      max_d       = max_q;
      len_d       = len_q;
      idx_d       = idx_q;
      sym_d       = sym_q;
      attempts_d  = attempts_q;
      fpwd_d      = fpwd_q;
      flen_d      = flen_q;
      sha_rst_o   = 1'b0;
      byte_rdy_o  = 1'b0;
      byte_stop_o = 1'b0;
      data_in_o   = 8'h00;

      case (state_q)
         S_CRST: begin
            idx_d   = '0;
            state_d = S_FEED;
         end
         S_FEED: begin
            sha_rst_o  = 1'b1;
            byte_rdy_o = 1'b1;
            data_in_o  = CHAR_BASE + 8'(cur_sym);
            if (overflow_err_i) begin
               state_d = S_ERR;
            end else if (idx_q == len_q - 4'd1) begin
               state_d = S_WAIT;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         S_WAIT: begin
            sha_rst_o   = 1'b1;
            byte_stop_o = 1'b1;
            if (overflow_err_i) begin
               state_d = S_ERR;
            end else if (hash_done_i) begin
               digest_d = hash_digest_i;
               state_d  = S_CMP;
            end
         end
         S_CMP: begin
            if (attempts_q != 32'hFFFF_FFFF) attempts_d = attempts_q + 32'd1;
            if (digest_q == target_q) begin
               fpwd_d  = cand_pwd;
               flen_d  = len_q;
               state_d = S_FOUND;
            end else begin
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (!inc_carry) begin
               sym_d   = inc_sym;
               state_d = S_CRST;
            end else if (({1'b0, len_q} + 5'd1) > {1'b0, max_q}) begin
               // len is left alone here so it never wraps when MAX_LEN is 15
               state_d = S_EXH;
            end else begin
               len_d = len_q + 4'd1;
               for (int i = 0; i < MAX_LEN; i++) sym_d[i] = '0;
               state_d = S_CRST;
            end
         end
         default: ;
      endcase

      if (start_ok) begin
         target_d   = target_hash_i;
         max_d      = clamp_len;
         attempts_d = '0;
         len_d      = 4'd1;
         for (int i = 0; i < MAX_LEN; i++) sym_d[i] = '0;
         fpwd_d     = '0;
         flen_d     = '0;
         state_d    = (clamp_len == 4'd0) ? S_EXH : S_CRST;
      end

      if (abort_i) begin
         fpwd_d  = '0;
         flen_d  = '0;
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q    <= S_IDLE;
         target_q   <= '0;
         digest_q   <= '0;
         max_q      <= '0;
         len_q      <= 4'd1;
         idx_q      <= '0;
         for (int i = 0; i < MAX_LEN; i++) sym_q[i] <= '0;
         attempts_q <= '0;
         fpwd_q     <= '0;
         flen_q     <= '0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         digest_q   <= digest_d;
         max_q      <= max_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         sym_q      <= sym_d;
         attempts_q <= attempts_d;
         fpwd_q     <= fpwd_d;
         flen_q     <= flen_d;
      end
   end

   assign busy_o      = (state_q == S_CRST) || (state_q == S_FEED) || (state_q == S_WAIT) ||
                        (state_q == S_CMP)  || (state_q == S_NEXT);
   assign found_o     = (state_q == S_FOUND);
   assign exhausted_o = (state_q == S_EXH);
   assign err_o       = (state_q == S_ERR);
   assign found_pwd_o = fpwd_q;
   assign found_len_o = flen_q;
   assign attempts_o  = attempts_q;

endmodule

// File: tb/tb_crack_ctrl.sv
// Directed bench for crack_ctrl around a stub hash core whose digest encodes
// the message bytes and length, with a fixed latency after end-of-message.
module tb_crack_ctrl;

   logic          clk = 1'b0;
   logic          reset, start, abort;
   logic [255:0]  target_hash;
   logic [3:0]    cfg_max_len;
   logic          sha_rst, byte_rdy, byte_stop;
   logic [7:0]    data_in;
   logic          hash_done = 1'b0;
   logic [255:0]  hash_digest;
   logic          overflow_err;
   logic          busy, found, exhausted, err;
   logic [63:0]   found_pwd;
   logic [3:0]    found_len;
   logic [31:0]   attempts;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        f;
      logic        e;
      logic [3:0]  l;
      logic [63:0] p;
      logic [31:0] a;
   } res_t;
   res_t       res_q[$];
   logic [7:0] byte_q[$];

   crack_ctrl #(.MAX_LEN(8), .CHARSET_SIZE(26), .CHAR_BASE(8'h61)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
      .target_hash_i(target_hash), .cfg_max_len_i(cfg_max_len),
      .sha_rst_o(sha_rst), .byte_rdy_o(byte_rdy), .byte_stop_o(byte_stop),
      .data_in_o(data_in), .hash_done_i(hash_done), .hash_digest_i(hash_digest),
      .overflow_err_i(overflow_err), .busy_o(busy), .found_o(found),
      .exhausted_o(exhausted), .err_o(err), .found_pwd_o(found_pwd),
      .found_len_o(found_len), .attempts_o(attempts)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] stub_dig(input logic [63:0] msg, input logic [3:0] len);
      return {64'hDEAD_BEEF_0123_4567, 120'h0, 4'h0, len, msg};
   endfunction

   // Stub core: collects bytes, raises hash_done 5 cycles into end-of-message.
   logic [63:0] s_msg;
   int          s_len, s_cnt;
   logic        s_done;
   logic        ovf_force;
   always @(posedge clk) begin
      if (!sha_rst) begin
         s_msg <= '0; s_len <= 0; s_cnt <= 0; s_done <= 1'b0; hash_done <= 1'b0;
      end else begin
         hash_done <= 1'b0;
         if (byte_rdy && s_len < 8) begin
            s_msg[s_len*8 +: 8] <= data_in;
            s_len <= s_len + 1;
         end
         if (byte_stop && !s_done) begin
            if (s_cnt == 4) begin
               hash_done <= 1'b1; s_done <= 1'b1; s_cnt <= 0;
            end else begin
               s_cnt <= s_cnt + 1;
            end
         end
      end
   end
   assign hash_digest  = stub_dig(s_msg, 4'(s_len));
   assign overflow_err = ovf_force;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_search(input string tag, input logic [255:0] tgt, input logic [3:0] cfg,
                             input logic ef, input logic ee, input logic [3:0] el,
                             input logic [63:0] ep, input logic [31:0] ea, input bit inject);
      res_t r;
      int   n;
      res_q.push_back('{f: ef, e: ee, l: el, p: ep, a: ea});
      target_hash = tgt; cfg_max_len = cfg; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (busy && n < 30000) begin
         if (inject && n == 3) begin
            start = 1'b1; target_hash = stub_dig(64'h61, 4'd1); cfg_max_len = 4'd1;
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
      end
      start = 1'b0;
      chk({tag, "_timeout"}, 256'(busy), 256'(0));
      r = res_q.pop_front();
      chk({tag, "_found"}, 256'(found), 256'(r.f));
      chk({tag, "_exh"}, 256'(exhausted), 256'(r.e));
      chk({tag, "_len"}, 256'(found_len), 256'(r.l));
      chk({tag, "_pwd"}, 256'(found_pwd), 256'(r.p));
      chk({tag, "_attempts"}, 256'(attempts), 256'(r.a));
   endtask

   initial begin
      int   n, cand, run;
      logic p_rdy, p_stop, p_done, p_sha, p_busy, p_bstop;
      logic [7:0] eb;

      reset = 1'b0; start = 1'b0; abort = 1'b0; ovf_force = 1'b0;
      target_hash = '0; cfg_max_len = '0;
      repeat (3) tick();
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_sha_rst", 256'(sha_rst), 256'(0));
      chk("rst_byte_rdy", 256'(byte_rdy), 256'(0));
      chk("rst_flags", 256'({found, exhausted, err, byte_stop}), 256'(0));
      chk("rst_attempts", 256'(attempts), 256'(0));
      chk("rst_pwd", 256'({found_pwd, found_len, data_in}), 256'(0));
      reset = 1'b1;
      tick();

      // single char, first candidate
      run_search("t1", stub_dig(64'h61, 4'd1), 4'd8, 1'b1, 1'b0, 4'd1, 64'h61, 32'd1, 1'b0);

      // abort and start together from FOUND: abort wins
      abort = 1'b1; start = 1'b1; target_hash = stub_dig(64'h61, 4'd1); cfg_max_len = 4'd8;
      tick();
      abort = 1'b0; start = 1'b0;
      chk("abort_start_busy", 256'(busy), 256'(0));
      chk("abort_start_found", 256'({found, found_len}), 256'(0));

      // "abc" with a start pulse mid-search that must be ignored
      run_search("t2", stub_dig(64'h636261, 4'd3), 4'd3, 1'b1, 1'b0, 4'd3, 64'h636261, 32'd731, 1'b1);
      run_search("t3", stub_dig(64'h636261, 4'd3), 4'd1, 1'b0, 1'b1, 4'd0, 64'h0, 32'd26, 1'b0);
      // carry from "az" to "ba"; cfg above MAX_LEN clamps
      run_search("carry", stub_dig(64'h6162, 4'd2), 4'd15, 1'b1, 1'b0, 4'd2, 64'h6162, 32'd53, 1'b0);

      // cfg_max_len 0: exhausted one cycle after start
      target_hash = stub_dig(64'h61, 4'd1); cfg_max_len = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("max0_exh", 256'(exhausted), 256'(1));
      chk("max0_busy_attempts", 256'({busy, attempts}), 256'(0));

      // T4: byte stream of "a".."z","aa","ab" against scoreboard
      for (int c = 0; c < 26; c++) byte_q.push_back(8'h61 + 8'(c));
      byte_q.push_back(8'h61); byte_q.push_back(8'h61);
      byte_q.push_back(8'h61); byte_q.push_back(8'h62);
      target_hash = '1; cfg_max_len = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0; cand = 0; run = 0;
      p_rdy = 1'b0; p_stop = 1'b0; p_done = 1'b0; p_sha = 1'b0; p_busy = 1'b1; p_bstop = 1'b0;
      while ((byte_q.size() > 0 || byte_rdy) && n < 3000) begin
         if (byte_rdy) begin
            if (!p_rdy && cand == 26)
               chk("t4_crst_before_aa", 256'({p_sha, p_busy, p_bstop, p_rdy}), 256'(4'b0100));
            if (byte_q.size() > 0) begin
               eb = byte_q.pop_front();
               chk("t4_byte", 256'(data_in), 256'(eb));
            end
            run++;
         end else if (p_rdy) begin
            cand++;
            if (cand == 27) chk("t4_aa_len", 256'(run), 256'(2));
            run = 0;
         end
         if (p_stop && !byte_stop) chk("t4_stop_until_done", 256'(p_done), 256'(1));
         p_rdy = byte_rdy; p_stop = byte_stop; p_done = hash_done;
         p_sha = sha_rst; p_busy = busy; p_bstop = byte_stop;
         tick();
         n++;
      end
      chk("t4_timeout", 256'(byte_q.size()), 256'(0));

      // T5: abort during FEED of the next candidate
      n = 0;
      while (!byte_rdy && n < 200) begin tick(); n++; end
      chk("t5_in_feed", 256'(byte_rdy), 256'(1));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_busy", 256'(busy), 256'(0));
      chk("t5_outs", 256'({sha_rst, byte_rdy, byte_stop}), 256'(0));
      target_hash = stub_dig(64'h61, 4'd1); cfg_max_len = 4'd4; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t5_restart_attempts", 256'(attempts), 256'(0));
      tick();
      chk("t5_first_byte", 256'({byte_rdy, data_in}), 256'({1'b1, 8'h61}));
      n = 0;
      while (busy && n < 200) begin tick(); n++; end
      chk("t5_found", 256'({found, found_len, attempts}), 256'({1'b1, 4'd1, 32'd1}));

      // T6: overflow during WAIT
      target_hash = '1; cfg_max_len = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!byte_stop && n < 200) begin tick(); n++; end
      ovf_force = 1'b1;
      tick();
      ovf_force = 1'b0;
      chk("t6_err", 256'(err), 256'(1));
      chk("t6_outs", 256'({busy, byte_stop, sha_rst, byte_rdy}), 256'(0));

      // restart from ERR, then reset mid-FEED after a few attempts
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_restart", 256'({busy, err}), 256'(2'b10));
      n = 0;
      while (attempts != 32'd3 && n < 500) begin tick(); n++; end
      while (!byte_rdy && n < 1000) begin tick(); n++; end
      chk("t6_pre_reset", 256'({byte_rdy, attempts}), 256'({1'b1, 32'd3}));
      reset = 1'b0;
      tick();
      chk("t6_reset_ctl", 256'({busy, sha_rst, byte_rdy, byte_stop, data_in}), 256'(0));
      chk("t6_reset_res", 256'({found, exhausted, err, attempts, found_pwd, found_len}), 256'(0));
      reset = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
